minesweeper_core: RTL and testbench

//  Parametrised game datapath+control for an R x C minesweeper board. Loads a mine map,

---
 rtl/minesweeper_pkg.sv | 29 ++
 rtl/minesweeper_if.sv | 30 +++
 rtl/ms_neighbor_walk.sv | 45 ++++
 rtl/minesweeper_core.sv | 192 +++++++++++++++++++
 tb/tb_minesweeper_core.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/minesweeper_pkg.sv
// Shared types, neighbour offset table and index helper for the minesweeper core.
// Cell index is row*COLS+col with bit 0 at (0,0).
package minesweeper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        COUNT,
        RESULT,
        OVER
    } state_t;

    typedef logic [3:0] count_t;

    localparam int NUM_STEPS = 8;

    // Neighbour walk order: row above left-to-right, same row left/right, row below.
    localparam logic signed [1:0] dRow [NUM_STEPS] = '{
        -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1
    };
    localparam logic signed [1:0] dCol [NUM_STEPS] = '{
        -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1
    };

    function automatic int idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/minesweeper_if.sv
// Guess/result handshake between the decode front end and the minesweeper core.
interface minesweeper_if
    import minesweeper_pkg::*;
#(
    parameter int ROWS = 5,
    parameter int COLS = 5
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic          guess_valid;
    logic [RW-1:0] guess_row;
    logic [CW-1:0] guess_col;
    logic          guess_ready;
    logic          result_valid;
    count_t        n_nearby;
    logic          hit_err;
    logic          repeat_hit;

    modport master (
        output guess_valid, guess_row, guess_col,
        input  guess_ready, result_valid, n_nearby, hit_err, repeat_hit
    );

    modport slave (
        input  guess_valid, guess_row, guess_col,
        output guess_ready, result_valid, n_nearby, hit_err, repeat_hit
    );

endinterface

// File: rtl/ms_neighbor_walk.sv
// Steps through the 8 neighbours of a cell, one per cycle while enabled,
// flagging neighbours that fall off the board (no wrap on rows or columns).
module ms_neighbor_walk
    import minesweeper_pkg::*;
#(
    parameter int ROWS = 5,
    parameter int COLS = 5,
    parameter int RW   = $clog2(ROWS),
    parameter int CW   = $clog2(COLS),
    parameter int IW   = $clog2(ROWS * COLS)
) (
    input  logic          clka,
    input  logic          restart,
    input  logic          en_i,
    input  logic [RW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    output logic          nb_valid_o,
    output logic [IW-1:0] nb_idx_o,
    output logic          walk_done_o
);

    logic [2:0] k_q;
    int         nbRow;
    int         nbCol;

    // Step counter parks at 0 whenever the walk is not enabled, so an abort needs no extra control.
    always_ff @(negedge clka) begin
        if (restart) begin
            k_q <= 3'd0;
        end else if (en_i) begin
            k_q <= k_q + 3'd1;
        end else begin
            k_q <= 3'd0;
        end
    end

    always_comb begin
        nbRow       = int'(row_i) + int'(dRow[k_q]);
        nbCol       = int'(col_i) + int'(dCol[k_q]);
        nb_valid_o  = en_i && (nbRow >= 0) && (nbRow < ROWS) && (nbCol >= 0) && (nbCol < COLS);
        nb_idx_o    = nb_valid_o ? IW'(idx(nbRow, nbCol, COLS)) : '0;
        walk_done_o = en_i && (k_q == 3'd7);
    end

endmodule

// File: rtl/minesweeper_core.sv
// Minesweeper game datapath and control: mine map, cleared map, guess evaluation,
// loss/win detection and a saturating win score. All state moves on negedge clka.
module minesweeper_core
    import minesweeper_pkg::*;
#(
    parameter int ROWS    = 5,
    parameter int COLS    = 5,
    parameter int SCORE_W = 32
) (
    input  logic                 clka,
    input  logic                 restart,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] mines_in,
    minesweeper_if.slave         gbus,
    output logic                 place_done,
    output logic                 gameover,
    output logic                 win,
    output logic [SCORE_W-1:0]   global_score,
    output logic [ROWS*COLS-1:0] cleared,
    output logic [ROWS*COLS-1:0] mines
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int IW = $clog2(N);

    state_t             state_q;
    logic [RW-1:0]      row_q;
    logic [CW-1:0]      col_q;
    count_t             acc_q;
    count_t             nNearby_q;
    logic               guessReady_q;
    logic               resultValid_q;
    logic               hitErr_q;
    logic               repeatHit_q;
    logic               placeDone_q;
    logic               gameover_q;
    logic               win_q;
    logic [SCORE_W-1:0] score_q;
    logic [N-1:0]       mines_q;
    logic [N-1:0]       cleared_q;

    logic               walkEn;
    logic               nbValid;
    logic [IW-1:0]      nbIdx;
    logic               walkDone;
    logic               nbHit;
    logic               handshake;
    logic               guessOff;
    logic [IW-1:0]      guessIdx;
    count_t             finalCount;
    logic [N-1:0]       clearedNext;
    logic               boardDone;

    assign walkEn      = (state_q == COUNT);
    assign handshake   = gbus.guess_valid && guessReady_q;
    assign guessOff    = (int'(gbus.guess_row) >= ROWS) || (int'(gbus.guess_col) >= COLS);
    assign guessIdx    = IW'(idx(int'(row_q), int'(col_q), COLS));
    assign nbHit       = nbValid && mines_q[nbIdx];
    // The last neighbour is folded in on the same edge that publishes the result.
    assign finalCount  = acc_q + count_t'(nbHit);
    assign clearedNext = cleared_q | (N'(1) << guessIdx);
    assign boardDone   = &(clearedNext | mines_q);

    ms_neighbor_walk #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW),
        .CW   (CW),
        .IW   (IW)
    ) u_walk (
        .clka        (clka),
        .restart     (restart),
        .en_i        (walkEn),
        .row_i       (row_q),
        .col_i       (col_q),
        .nb_valid_o  (nbValid),
        .nb_idx_o    (nbIdx),
        .walk_done_o (walkDone)
    );

    // Game FSM with registered outputs; restart beats start, start beats any guess in flight.
    always_ff @(negedge clka) begin
        if (restart) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            acc_q         <= '0;
            nNearby_q     <= '0;
            guessReady_q  <= 1'b0;
            resultValid_q <= 1'b0;
            hitErr_q      <= 1'b0;
            repeatHit_q   <= 1'b0;
            placeDone_q   <= 1'b0;
            gameover_q    <= 1'b0;
            win_q         <= 1'b0;
            score_q       <= '0;
            mines_q       <= '0;
            cleared_q     <= '0;
        end else begin
            placeDone_q   <= 1'b0;
            resultValid_q <= 1'b0;
            if (start) begin
                mines_q      <= mines_in;
                cleared_q    <= '0;
                gameover_q   <= 1'b0;
                win_q        <= 1'b0;
                nNearby_q    <= '0;
                acc_q        <= '0;
                guessReady_q <= 1'b1;
                placeDone_q  <= 1'b1;
                state_q      <= READY;
            end else begin
                case (state_q)
                    IDLE: begin
                        guessReady_q <= 1'b0;
                    end
                    READY: begin
                        if (handshake) begin
                            row_q <= gbus.guess_row;
                            col_q <= gbus.guess_col;
                            if (guessOff) begin
                                resultValid_q <= 1'b1;
                                hitErr_q      <= 1'b1;
                                repeatHit_q   <= 1'b0;
                                nNearby_q     <= '0;
                            end else begin
                                acc_q        <= '0;
                                guessReady_q <= 1'b0;
                                state_q      <= COUNT;
                            end
                        end
                    end
                    COUNT: begin
                        if (walkDone) begin
                            resultValid_q <= 1'b1;
                            hitErr_q      <= 1'b0;
                            repeatHit_q   <= cleared_q[guessIdx];
                            cleared_q     <= clearedNext;
                            state_q       <= RESULT;
                            if (mines_q[guessIdx]) begin
                                nNearby_q  <= finalCount;
                                gameover_q <= 1'b1;
                            end else if (boardDone) begin
                                nNearby_q  <= '0;
                                win_q      <= 1'b1;
                                gameover_q <= 1'b1;
                                if (score_q != '1) begin
                                    score_q <= score_q + 1'b1;
                                end
                            end else begin
                                nNearby_q <= finalCount;
                            end
                        end else if (nbHit) begin
                            acc_q <= acc_q + 4'd1;
                        end
                    end
                    RESULT: begin
                        if (gameover_q) begin
                            guessReady_q <= 1'b0;
                            state_q      <= OVER;
                        end else begin
                            guessReady_q <= 1'b1;
                            state_q      <= READY;
                        end
                    end
                    OVER: begin
                        guessReady_q <= 1'b0;
                    end
                    default: begin
                        guessReady_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                endcase
            end
        end
    end

    assign gbus.guess_ready  = guessReady_q;
    assign gbus.result_valid = resultValid_q;
    assign gbus.n_nearby     = nNearby_q;
    assign gbus.hit_err      = hitErr_q;
    assign gbus.repeat_hit   = repeatHit_q;
    assign place_done        = placeDone_q;
    assign gameover          = gameover_q;
    assign win               = win_q;
    assign global_score      = score_q;
    assign cleared           = cleared_q;
    assign mines             = mines_q;

endmodule

// File: tb/tb_minesweeper_core.sv
// Directed bench for minesweeper_core on a 5x5 board with mines at idx 1,3,5,15.
// Inputs change and outputs are sampled on posedge, half a cycle from the active negedge.
module tb_minesweeper_core;
    import minesweeper_pkg::*;

    localparam int ROWS    = 5;
    localparam int COLS    = 5;
    localparam int SCORE_W = 2;
    localparam int N       = ROWS * COLS;
    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);
    localparam logic [N-1:0] MINE_MAP = 25'b0000000001000000000101010;

    // Every non-mine cell with its hand-counted neighbour mines; (0,4) goes last and wins.
    localparam int cellR [21] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 4, 0};
    localparam int cellC [21] = '{0, 2, 1, 2, 3, 4, 0, 1, 2, 3, 4, 1, 2, 3, 4, 0, 1, 2, 3, 4, 4};
    localparam int cellN [21] = '{2, 2, 2, 2, 1, 1, 2, 2, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1};

    logic               clka = 1'b0;
    logic               restart;
    logic               start;
    logic [N-1:0]       mines_in;
    logic               place_done;
    logic               gameover;
    logic               win;
    logic [SCORE_W-1:0] global_score;
    logic [N-1:0]       cleared;
    logic [N-1:0]       mines;

    int checks = 0;
    int errors = 0;

    minesweeper_if #(.ROWS(ROWS), .COLS(COLS)) gbus ();

    minesweeper_core #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .SCORE_W (SCORE_W)
    ) dut (
        .clka         (clka),
        .restart      (restart),
        .start        (start),
        .mines_in     (mines_in),
        .gbus         (gbus),
        .place_done   (place_done),
        .gameover     (gameover),
        .win          (win),
        .global_score (global_score),
        .cleared      (cleared),
        .mines        (mines)
    );

    always #5 clka = ~clka;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog timeout");
    end

    task automatic tick();
        @(posedge clka);
    endtask

    task automatic doStart(input logic [N-1:0] m);
        start    = 1'b1;
        mines_in = m;
        tick();
        start    = 1'b0;
    endtask

    // Waits for guess_ready, offers one guess, returns cycles until result_valid (-1 on timeout).
    task automatic doGuess(input int r, input int c, output int lat);
        for (int w = 0; w < 20 && gbus.guess_ready !== 1'b1; w++) tick();
        gbus.guess_valid = 1'b1;
        gbus.guess_row   = RW'(r);
        gbus.guess_col   = CW'(c);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) gbus.guess_valid = 1'b0;
            if (gbus.result_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        restart = 1'b1;
        start = 1'b0;
        mines_in = '0;
        gbus.guess_valid = 1'b0;
        gbus.guess_row = '0;
        gbus.guess_col = '0;
        tick();
        tick();
        restart = 1'b0;
        checks++; if (gbus.guess_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %0b want 0", gbus.guess_ready); end
        checks++; if (gbus.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rv got %0b want 0", gbus.result_valid); end
        checks++; if (global_score !== '0) begin errors++; $display("[TB] FAIL reset_score got %0d want 0", global_score); end
        checks++; if ({gameover, win, place_done} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {gameover, win, place_done}); end
        checks++; if (mines !== '0 || cleared !== '0) begin errors++; $display("[TB] FAIL reset_maps got %h/%h want 0/0", mines, cleared); end
        tick();
        checks++; if (gbus.guess_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready got %0b want 0", gbus.guess_ready); end
    endtask

    task automatic test_basic();
        int lat;
        doStart(MINE_MAP);
        checks++; if (place_done !== 1'b1) begin errors++; $display("[TB] FAIL place_done got %0b want 1", place_done); end
        checks++; if (mines !== MINE_MAP) begin errors++; $display("[TB] FAIL mines_latch got %h want %h", mines, MINE_MAP); end
        checks++; if (gbus.guess_ready !== 1'b1) begin errors++; $display("[TB] FAIL start_ready got %0b want 1", gbus.guess_ready); end
        tick();
        checks++; if (place_done !== 1'b0) begin errors++; $display("[TB] FAIL place_pulse got %0b want 0", place_done); end
        doGuess(1, 1, lat);
        checks++; if (lat != 9) begin errors++; $display("[TB] FAIL lat_11 got %0d want 9", lat); end
        checks++; if (gbus.n_nearby !== 4'd2) begin errors++; $display("[TB] FAIL count_11 got %0d want 2", gbus.n_nearby); end
        checks++; if (gameover !== 1'b0 || gbus.repeat_hit !== 1'b0 || gbus.hit_err !== 1'b0) begin errors++; $display("[TB] FAIL flags_11 got %b want 000", {gameover, gbus.repeat_hit, gbus.hit_err}); end
        checks++; if (cleared !== (N'(1) << 6)) begin errors++; $display("[TB] FAIL cleared_11 got %h want %h", cleared, N'(1) << 6); end
        doGuess(0, 0, lat);
        checks++; if (lat != 9 || gbus.n_nearby !== 4'd2) begin errors++; $display("[TB] FAIL corner_00 got lat %0d n %0d want 9 2", lat, gbus.n_nearby); end
        doGuess(2, 4, lat);
        checks++; if (lat != 9 || gbus.n_nearby !== 4'd0) begin errors++; $display("[TB] FAIL edge_24 got lat %0d n %0d want 9 0", lat, gbus.n_nearby); end
    endtask

    task automatic test_hit_err();
        int lat;
        int seen;
        doGuess(5, 0, lat);
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL err_lat got %0d want 1", lat); end
        checks++; if (gbus.hit_err !== 1'b1 || gbus.n_nearby !== 4'd0) begin errors++; $display("[TB] FAIL err_flags got %0b %0d want 1 0", gbus.hit_err, gbus.n_nearby); end
        checks++; if (gbus.guess_ready !== 1'b1) begin errors++; $display("[TB] FAIL err_ready got %0b want 1", gbus.guess_ready); end
        doGuess(1, 0, lat);
        checks++; if (lat != 9 || gameover !== 1'b1 || win !== 1'b0) begin errors++; $display("[TB] FAIL loss got lat %0d go %0b win %0b want 9 1 0", lat, gameover, win); end
        gbus.guess_valid = 1'b1;
        gbus.guess_row = RW'(2);
        gbus.guess_col = CW'(2);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gbus.guess_ready !== 1'b0 || gbus.result_valid !== 1'b0) seen++;
        end
        gbus.guess_valid = 1'b0;
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL over_idle got %0d active cycles want 0", seen); end
    endtask

    task automatic test_repeat();
        int lat;
        int seen;
        doStart(MINE_MAP);
        doGuess(1, 1, lat);
        checks++; if (gbus.repeat_hit !== 1'b0) begin errors++; $display("[TB] FAIL first_repeat got %0b want 0", gbus.repeat_hit); end
        doGuess(1, 1, lat);
        checks++; if (lat != 9 || gbus.repeat_hit !== 1'b1 || gbus.n_nearby !== 4'd2) begin errors++; $display("[TB] FAIL second_repeat got lat %0d rep %0b n %0d want 9 1 2", lat, gbus.repeat_hit, gbus.n_nearby); end
        checks++; if (cleared !== (N'(1) << 6)) begin errors++; $display("[TB] FAIL repeat_cleared got %h want %h", cleared, N'(1) << 6); end
        for (int w = 0; w < 20 && gbus.guess_ready !== 1'b1; w++) tick();
        gbus.guess_valid = 1'b1;
        gbus.guess_row = RW'(2);
        gbus.guess_col = CW'(2);
        tick();
        gbus.guess_valid = 1'b0;
        tick();
        tick();
        tick();
        doStart(MINE_MAP);
        checks++; if (place_done !== 1'b1 || gbus.guess_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_start got pd %0b rdy %0b want 1 1", place_done, gbus.guess_ready); end
        checks++; if (cleared !== '0) begin errors++; $display("[TB] FAIL abort_cleared got %h want 0", cleared); end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (gbus.result_valid !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL abort_result got %0d pulses want 0", seen); end
    endtask

    task automatic test_win();
        int lat;
        logic [SCORE_W-1:0] expScore;
        for (int g = 1; g <= 4; g++) begin
            doStart(MINE_MAP);
            for (int i = 0; i < 21; i++) begin
                doGuess(cellR[i], cellC[i], lat);
                if (i < 20) begin
                    if (g == 1) begin
                        checks++; if (lat != 9 || gbus.n_nearby !== 4'(cellN[i]) || gameover !== 1'b0) begin errors++; $display("[TB] FAIL walk_%0d_%0d got lat %0d n %0d go %0b want 9 %0d 0", cellR[i], cellC[i], lat, gbus.n_nearby, gameover, cellN[i]); end
                    end
                end else begin
                    expScore = (g >= 3) ? 2'd3 : SCORE_W'(g);
                    checks++; if (lat != 9 || win !== 1'b1 || gameover !== 1'b1 || gbus.n_nearby !== 4'd0) begin errors++; $display("[TB] FAIL win_%0d got lat %0d win %0b go %0b n %0d want 9 1 1 0", g, lat, win, gameover, gbus.n_nearby); end
                    checks++; if (global_score !== expScore) begin errors++; $display("[TB] FAIL score_%0d got %0d want %0d", g, global_score, expScore); end
                end
            end
            tick();
            checks++; if (gbus.guess_ready !== 1'b0) begin errors++; $display("[TB] FAIL win_ready_%0d got %0b want 0", g, gbus.guess_ready); end
        end
    endtask

    task automatic test_restart();
        int seen;
        doStart(MINE_MAP);
        for (int w = 0; w < 20 && gbus.guess_ready !== 1'b1; w++) tick();
        gbus.guess_valid = 1'b1;
        gbus.guess_row = RW'(1);
        gbus.guess_col = CW'(1);
        tick();
        gbus.guess_valid = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (global_score !== '0) begin errors++; $display("[TB] FAIL rst_score got %0d want 0", global_score); end
        checks++; if ({gbus.guess_ready, gbus.result_valid, gbus.hit_err, gbus.repeat_hit, gameover, win, place_done} !== 7'b0) begin errors++; $display("[TB] FAIL rst_flags got %b want 0000000", {gbus.guess_ready, gbus.result_valid, gbus.hit_err, gbus.repeat_hit, gameover, win, place_done}); end
        checks++; if (mines !== '0 || cleared !== '0 || gbus.n_nearby !== 4'd0) begin errors++; $display("[TB] FAIL rst_data got %h %h %0d want 0 0 0", mines, cleared, gbus.n_nearby); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gbus.guess_ready !== 1'b0 || gbus.result_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL rst_idle got %0d active cycles want 0", seen); end
        doStart(MINE_MAP);
        checks++; if (gbus.guess_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_restart got %0b want 1", gbus.guess_ready); end
    endtask

    initial begin
        $display("[TB] minesweeper_core directed test start");
        test_reset();
        test_basic();
        test_hit_err();
        test_repeat();
        test_win();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
